// File: rtl/cmp_pkg.sv
// Shared types and helpers for the chunked magnitude comparator.
// Latency: none (package only).
// Backpressure: none (package only).
package cmp_pkg;

    // FSM state encoding
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // 2-bit per-chunk / overall result code
    localparam logic [1:0] RES_EQ = 2'b00;
    localparam logic [1:0] RES_GT = 2'b01;
    localparam logic [1:0] RES_LT = 2'b10;

    // Number of W-bit chunks in an N-bit operand (guards divide-by-zero so
    // the elaboration check in the top can report the real problem)
    function automatic int chunk_count(input int n, input int w);
        return (w > 0) ? (n / w) : 1;
    endfunction

    // Width of the chunk index register, never less than one bit
    function automatic int idx_width(input int c);
        return (c <= 1) ? 1 : $clog2(c);
    endfunction

endpackage

// File: rtl/chunk_compare.sv
// Combinational W-bit compare returning EQ/GT/LT, optionally two's-complement.
// Latency: zero cycles (pure combinational).
// Backpressure: none; result follows the inputs.
module chunk_compare
    import cmp_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         signed_en,
    output logic [1:0]   res
);

    logic a_gt;

    // Pick signed or unsigned ordering, then fold into the result code
    always_comb begin
        a_gt = signed_en ? ($signed(a) > $signed(b)) : (a > b);
        if (a == b) begin
            res = RES_EQ;
        end else if (a_gt) begin
            res = RES_GT;
        end else begin
            res = RES_LT;
        end
    end

endmodule

// File: rtl/chunked_magnitude_comparator.sv
// Sequential N-bit magnitude compare, W bits per cycle from the MSB chunk; optional CMP_EARLY_EXIT_EN.
// Latency: C=N/W cycles from the start edge to done (1..C with CMP_EARLY_EXIT_EN).
// Backpressure: start is ignored while busy; accepted again in the done cycle.
module chunked_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         signed_mode,
    output logic         busy,
    output logic         done,
    output logic         equal,
    output logic         greater,
    output logic         less
);

    localparam int C  = chunk_count(N, W);
    localparam int IW = idx_width(C);

    localparam logic [IW-1:0] IDX_TOP = IW'(C - 1);
    localparam logic [0:0]    S_IDLE  = 1'(IDLE);
    localparam logic [0:0]    S_RUN   = 1'(RUN);

    // Reject chunkings that do not tile the operand exactly
    if ((W < 1) || ((N % W) != 0)) begin : g_bad_chunking
        $error("chunked_magnitude_comparator: N must be a positive multiple of W");
    end

    logic [0:0]    state;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic          sgn_q;
    logic [IW-1:0] idx;
    logic [1:0]    dec;

    logic [W-1:0]  a_chunk;
    logic [W-1:0]  b_chunk;
    logic          chunk_signed;
    logic [1:0]    chunk_res;
    logic [1:0]    dec_next;
    logic          finish;

    assign busy = (state == S_RUN);

    // Select the chunk under test; only the top chunk carries the sign
    always_comb begin
        a_chunk      = a_q[int'(idx) * W +: W];
        b_chunk      = b_q[int'(idx) * W +: W];
        chunk_signed = sgn_q && (idx == IDX_TOP);
    end

    chunk_compare #(.W(W)) u_chunk_compare (
        .a         (a_chunk),
        .b         (b_chunk),
        .signed_en (chunk_signed),
        .res       (chunk_res)
    );

    // First differing chunk fixes the decision; later chunks cannot override it
    always_comb begin
        dec_next = (dec == RES_EQ) ? chunk_res : dec;
`ifdef CMP_EARLY_EXIT_EN
        finish   = (idx == '0) || (dec_next != RES_EQ);
`else
        finish   = (idx == '0);
`endif
    end

    // Handshake FSM, operand capture, chunk walk and registered result flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            idx     <= '0;
            dec     <= RES_EQ;
            done    <= 1'b0;
            equal   <= 1'b0;
            greater <= 1'b0;
            less    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        sgn_q <= signed_mode;
                        idx   <= IDX_TOP;
                        dec   <= RES_EQ;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    dec <= dec_next;
                    if (finish) begin
                        state   <= S_IDLE;
                        done    <= 1'b1;
                        equal   <= (dec_next == RES_EQ);
                        greater <= (dec_next == RES_GT);
                        less    <= (dec_next == RES_LT);
                    end else if (idx != '0) begin
                        idx <= idx - IW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_magnitude_comparator.sv
// Directed bench for chunked_magnitude_comparator at N=32, W=8 (C=4).
// Latency expectations follow CMP_EARLY_EXIT_EN when defined.
// Drives on posedge+1, samples on posedge+1.
module tb_chunked_magnitude_comparator;

    localparam int N = 32;
    localparam int W = 8;
    localparam int C = N / W;
`ifdef CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam logic [2:0] F_EQ   = 3'b100;
    localparam logic [2:0] F_GT   = 3'b010;
    localparam logic [2:0] F_LT   = 3'b001;
    localparam logic [2:0] F_NONE = 3'b000;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         signed_mode;
    logic         busy;
    logic         done;
    logic         equal;
    logic         greater;
    logic         less;

    int vec_cnt  = 0;
    int fail_cnt = 0;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         sm;
        logic [2:0]   flags;
        int           k;
    } vec_t;

    chunked_magnitude_comparator #(.N(N), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (A),
        .B           (B),
        .signed_mode (signed_mode),
        .busy        (busy),
        .done        (done),
        .equal       (equal),
        .greater     (greater),
        .less        (less)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] flags_now();
        return {equal, greater, less};
    endfunction

    function automatic int exp_lat(input int k);
        return EARLY ? k : C;
    endfunction

    // Present a request and let the next edge accept it
    task automatic start_cmp(input logic [N-1:0] a, input logic [N-1:0] b, input logic sm);
        A           = a;
        B           = b;
        signed_mode = sm;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Cycles from the accept edge to the edge raising done; -1 on timeout
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 2 * C + 8; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        signed_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vec_cnt++;
        if ({busy, done} !== 2'b00) begin
            fail_cnt++;
            $display("FAIL reset_busy_done: got %b want 00", {busy, done});
        end
        vec_cnt++;
        if (flags_now() !== F_NONE) begin
            fail_cnt++;
            $display("FAIL reset_flags: got %b want 000", flags_now());
        end
        rst = 1'b0;
    endtask

    task automatic test_compare_vectors();
        vec_t tbl[12];
        int   n;
        tbl[0]  = '{32'h12345678, 32'h12345678, 1'b0, F_EQ, 4};
        tbl[1]  = '{32'h80000000, 32'h7FFFFFFF, 1'b0, F_GT, 1};
        tbl[2]  = '{32'h80000000, 32'h7FFFFFFF, 1'b1, F_LT, 1};
        tbl[3]  = '{32'h12345679, 32'h12345678, 1'b0, F_GT, 4};
        tbl[4]  = '{32'hFF000000, 32'h00000000, 1'b1, F_LT, 1};
        tbl[5]  = '{32'hFF000000, 32'h00000000, 1'b0, F_GT, 1};
        tbl[6]  = '{32'h000000FF, 32'h00000001, 1'b1, F_GT, 4};
        tbl[7]  = '{32'h00800000, 32'h00000000, 1'b1, F_GT, 2};
        tbl[8]  = '{32'h02000000, 32'h01FFFFFF, 1'b0, F_GT, 1};
        tbl[9]  = '{32'h7F000000, 32'h80000000, 1'b1, F_GT, 1};
        tbl[10] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, F_GT, 4};
        tbl[11] = '{32'h12340000, 32'h1234FF00, 1'b0, F_LT, 3};
        for (int i = 0; i < 12; i++) begin
            start_cmp(tbl[i].a, tbl[i].b, tbl[i].sm);
            vec_cnt++;
            if (busy !== 1'b1) begin
                fail_cnt++;
                $display("FAIL vec%0d_busy: got %b want 1", i, busy);
            end
            wait_done(n);
            vec_cnt++;
            if (n !== exp_lat(tbl[i].k)) begin
                fail_cnt++;
                $display("FAIL vec%0d_latency: got %0d want %0d", i, n, exp_lat(tbl[i].k));
            end
            vec_cnt++;
            if ({busy, flags_now()} !== {1'b0, tbl[i].flags}) begin
                fail_cnt++;
                $display("FAIL vec%0d_flags: got busy=%b flags=%b want busy=0 flags=%b",
                         i, busy, flags_now(), tbl[i].flags);
            end
            @(posedge clk);
            #1;
            vec_cnt++;
            if ({done, flags_now()} !== {1'b0, tbl[i].flags}) begin
                fail_cnt++;
                $display("FAIL vec%0d_after_done: got done=%b flags=%b want done=0 flags=%b",
                         i, done, flags_now(), tbl[i].flags);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int n;
        // Previous result is LT; 5 vs 2 must win over the ignored 1 vs 9
        start_cmp(32'd5, 32'd2, 1'b0);
        start       = 1'b1;
        A           = 32'd1;
        B           = 32'd9;
        signed_mode = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            vec_cnt++;
            if ({busy, done, flags_now()} !== {2'b10, F_LT}) begin
                fail_cnt++;
                $display("FAIL busy_ignore_hold%0d: got busy=%b done=%b flags=%b want 1 0 %b",
                         i, busy, done, flags_now(), F_LT);
            end
        end
        start = 1'b0;
        wait_done(n);
        vec_cnt++;
        if (n !== exp_lat(4) - 2) begin
            fail_cnt++;
            $display("FAIL busy_ignore_latency: got %0d want %0d", n, exp_lat(4) - 2);
        end
        vec_cnt++;
        if (flags_now() !== F_GT) begin
            fail_cnt++;
            $display("FAIL busy_ignore_result: got %b want %b", flags_now(), F_GT);
        end
    endtask

    task automatic test_reset_abort();
        int dones;
        @(posedge clk);
        #1;
        start_cmp(32'd3, 32'd7, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        vec_cnt++;
        if ({busy, done, flags_now()} !== {2'b00, F_NONE}) begin
            fail_cnt++;
            $display("FAIL abort_state: got busy=%b done=%b flags=%b want 0 0 000",
                     busy, done, flags_now());
        end
        rst   = 1'b0;
        dones = 0;
        for (int i = 0; i < 2 * C; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        vec_cnt++;
        if ({dones, flags_now()} !== {32'd0, F_NONE}) begin
            fail_cnt++;
            $display("FAIL abort_quiet: got done/busy cycles=%0d flags=%b want 0 000",
                     dones, flags_now());
        end
    endtask

    task automatic test_back_to_back();
        int n;
        start_cmp(32'd9, 32'd3, 1'b0);
        wait_done(n);
        vec_cnt++;
        if ({n, flags_now()} !== {exp_lat(4), F_GT}) begin
            fail_cnt++;
            $display("FAIL b2b_first: got lat=%0d flags=%b want lat=%0d flags=%b",
                     n, flags_now(), exp_lat(4), F_GT);
        end
        // Issue the next request in the done cycle itself
        start_cmp(32'd1, 32'd2, 1'b0);
        vec_cnt++;
        if ({busy, done, flags_now()} !== {2'b10, F_GT}) begin
            fail_cnt++;
            $display("FAIL b2b_accept: got busy=%b done=%b flags=%b want 1 0 %b",
                     busy, done, flags_now(), F_GT);
        end
        wait_done(n);
        vec_cnt++;
        if ({n, flags_now()} !== {exp_lat(4), F_LT}) begin
            fail_cnt++;
            $display("FAIL b2b_second: got lat=%0d flags=%b want lat=%0d flags=%b",
                     n, flags_now(), exp_lat(4), F_LT);
        end
    endtask

    initial begin
        test_reset();
        test_compare_vectors();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
